// File: rtl/bus_pkg.sv
// bus_pkg: shared response encodings, master states and default widths
package bus_pkg;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_ADDR_W = 12;
    localparam int BUS_SLV_W  = 2;
    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } resp_e;
    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DONE} state_e;
endpackage

// File: rtl/bus_master_burst_if.sv
// bus_master_burst_if: arbitrated bus between the burst master and the arbiter/slave side
interface bus_master_burst_if
    import bus_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int SLV_W  = BUS_SLV_W
);
    logic              HGRANT;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [DATA_W-1:0] HRDATA;
    logic              HREQ;
    logic              HLOCK;
    logic [SLV_W-1:0]  HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [DATA_W-1:0] HWDATA;
    modport master (input HGRANT, HREADY, HRESP, HRDATA, output HREQ, HLOCK, HSEL, HADDR, HWRITE, HWDATA);
    modport slave (output HGRANT, HREADY, HRESP, HRDATA, input HREQ, HLOCK, HSEL, HADDR, HWRITE, HWDATA);
endinterface

// File: rtl/bus_beat_ctr.sv
// bus_beat_ctr: beat index and wrapping byte address for one burst
module bus_beat_ctr #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 4,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [LEN_W-1:0] beat_q;
    logic [LEN_W-1:0] len_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr   <= '0;
            beat_q <= '0;
            len_q  <= '0;
        end else if (load) begin
            addr   <= start_addr;
            beat_q <= '0;
            len_q  <= len;
        end else if (inc) begin
            addr   <= addr + ADDR_W'(STEP);
            beat_q <= beat_q + LEN_W'(1);
        end
    assign last = beat_q == len_q;
endmodule

// File: rtl/bus_master_burst.sv
// bus_master_burst: burst bus master with arbitration, wait states,
// retry/split replay of the current beat and abort on error or retry exhaustion
module bus_master_burst
    import bus_pkg::*;
#(
    parameter int DATA_W    = BUS_DATA_W,
    parameter int ADDR_W    = BUS_ADDR_W,
    parameter int SLV_W     = BUS_SLV_W,
    parameter int LEN_W     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              U_REQ,
    input  logic              U_LOCK,
    input  logic              U_WRITE,
    input  logic [ADDR_W-1:0] U_ADDR,
    input  logic [DATA_W-1:0] U_WDATA,
    input  logic [SLV_W-1:0]  U_SLAVE,
    input  logic [LEN_W-1:0]  U_LEN,
    output logic              U_WREADY,
    output logic [DATA_W-1:0] U_RDATA,
    output logic              U_RVALID,
    output logic              U_BUSY,
    output logic              U_DONE,
    output logic              U_ERR,
    bus_master_burst_if.master bus
);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    state_e            state_q, state_d;
    logic              lock_q, write_q, err_q, held_q;
    logic [SLV_W-1:0]  slave_q;
    logic [RTY_W-1:0]  retry_q;
    logic [ADDR_W-1:0] addr;
    logic              last, load, inc, resp_v, beat_ok, beat_rty, beat_err, phase;
    assign resp_v   = state_q == DATA && bus.HREADY;
    assign beat_ok  = resp_v && bus.HRESP == RESP_OKAY;
    assign beat_rty = resp_v && bus.HRESP[1];
    assign beat_err = resp_v && bus.HRESP == RESP_ERROR || beat_rty && retry_q == RTY_W'(MAX_RETRY - 1);
    assign load     = state_q == IDLE && U_REQ;
    assign inc      = beat_ok && !last;
    bus_beat_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .STEP(DATA_W / 8)) u_ctr (
        .clk(CLK), .rst_n(RST), .load(load), .inc(inc),
        .start_addr(U_ADDR), .len(U_LEN), .addr(addr), .last(last)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = U_REQ ? REQ : IDLE;
            REQ:     state_d = bus.HGRANT ? ADDR : REQ;
            ADDR:    state_d = DATA;
            DATA:    state_d = beat_err || beat_ok && last ? DONE :
                               beat_ok && bus.HGRANT ? ADDR :
                               beat_ok || beat_rty ? REQ : DATA;
            default: state_d = IDLE;
        endcase
    end
    // a replayed write beat keeps the held HWDATA, so only the first ADDR of a beat consumes user data
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state_q    <= IDLE;
            lock_q     <= 1'b0;
            write_q    <= 1'b0;
            slave_q    <= '0;
            err_q      <= 1'b0;
            held_q     <= 1'b0;
            retry_q    <= '0;
            bus.HWDATA <= '0;
            U_RDATA    <= '0;
            U_RVALID   <= 1'b0;
        end else begin
            state_q  <= state_d;
            U_RVALID <= beat_ok && !write_q;
            if (load) begin
                lock_q  <= U_LOCK;
                write_q <= U_WRITE;
                slave_q <= U_SLAVE;
                err_q   <= 1'b0;
                held_q  <= 1'b0;
                retry_q <= '0;
            end
            if (U_WREADY) begin
                bus.HWDATA <= U_WDATA;
                held_q     <= 1'b1;
            end
            if (beat_ok && !write_q) U_RDATA <= bus.HRDATA;
            if (inc) begin
                held_q  <= 1'b0;
                retry_q <= '0;
            end
            if (beat_rty) retry_q <= retry_q + RTY_W'(1);
            if (beat_err) err_q <= 1'b1;
        end
    assign phase      = state_q == ADDR || state_q == DATA;
    assign U_WREADY   = state_q == ADDR && write_q && !held_q;
    assign U_BUSY     = state_q != IDLE;
    assign U_DONE     = state_q == DONE;
    assign U_ERR      = U_DONE && err_q;
    assign bus.HREQ   = state_q == REQ || phase;
    assign bus.HLOCK  = bus.HREQ && lock_q;
    assign bus.HADDR  = phase ? addr : '0;
    assign bus.HSEL   = phase ? slave_q : '0;
    assign bus.HWRITE = phase && write_q;
endmodule

// File: tb/tb_bus_master_burst.sv
// tb_bus_master_burst: directed and randomized bursts checked against a beat/retry reference model
module tb_bus_master_burst;
    import bus_pkg::*;
    localparam int MAX_RETRY = 3;
    logic        CLK = 1'b0, RST = 1'b0;
    logic        U_REQ = 1'b0, U_LOCK = 1'b0, U_WRITE = 1'b0;
    logic [11:0] U_ADDR = '0;
    logic [31:0] U_WDATA = '0;
    logic [1:0]  U_SLAVE = '0;
    logic [3:0]  U_LEN = '0;
    logic        U_WREADY, U_RVALID, U_BUSY, U_DONE, U_ERR;
    logic [31:0] U_RDATA;
    int          checks = 0, failures = 0;
    logic [31:0] wdat [16];
    logic [1:0]  resp_q [$];
    int          wait_q [$];
    int          gdly = -1, rnd_pct = 0;
    bit          hr_idx = 1'b0;
    bus_master_burst_if bus ();
    bus_master_burst dut (
        .CLK(CLK), .RST(RST), .U_REQ(U_REQ), .U_LOCK(U_LOCK), .U_WRITE(U_WRITE),
        .U_ADDR(U_ADDR), .U_WDATA(U_WDATA), .U_SLAVE(U_SLAVE), .U_LEN(U_LEN),
        .U_WREADY(U_WREADY), .U_RDATA(U_RDATA), .U_RVALID(U_RVALID), .U_BUSY(U_BUSY),
        .U_DONE(U_DONE), .U_ERR(U_ERR), .bus(bus)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, 32'({bus.HREQ, bus.HLOCK, bus.HSEL, bus.HWRITE, U_WREADY, U_RVALID, U_BUSY, U_DONE, U_ERR}), 0);
        chk({tag, "_haddr"}, 32'(bus.HADDR), 0);
        chk({tag, "_hwdata"}, bus.HWDATA, 0);
        chk({tag, "_rdata"}, U_RDATA, 0);
    endtask
    function automatic logic [1:0] pick_resp();
        return $urandom_range(0, 99) < rnd_pct ? 2'($urandom_range(1, 3)) : 2'b00;
    endfunction
    task automatic fill_wdat();
        foreach (wdat[i]) wdat[i] = $urandom;
    endtask
    // model tracks beat index, retry count and whether the bus side is requesting, addressing or in data
    task automatic run_burst(input logic wr, input logic lk, input logic [11:0] a, input logic [3:0] len,
                             input logic [1:0] sl, input bit rst_mid);
        int b = 0, r = 0, ph = 1, wc = 0, cyc = 0, nreq = 0, gd, n_wr = 0, n_rv = 0, exp_rv = 0;
        logic err = 1'b0, rv_exp = 1'b0;
        logic [31:0] rd_exp = '0;
        logic [1:0] resp = 2'b00;
        logic [11:0] ea;
        U_REQ = 1'b1; U_WRITE = wr; U_LOCK = lk; U_ADDR = a; U_LEN = len; U_SLAVE = sl;
        gd = gdly >= 0 ? gdly : $urandom_range(0, 2);
        while (ph != 0 && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            ea = a + 12'(4 * b);
            chk("hreq", 32'(bus.HREQ), 32'(ph >= 1 && ph <= 3));
            chk("hlock", 32'(bus.HLOCK), 32'(lk && ph >= 1 && ph <= 3));
            chk("busy", 32'(U_BUSY), 1);
            chk("wready", 32'(U_WREADY), 32'(ph == 2 && wr && r == 0));
            chk("rvalid", 32'(U_RVALID), 32'(rv_exp));
            if (rv_exp) chk("rdata", U_RDATA, rd_exp);
            chk("done", 32'(U_DONE), 32'(ph == 4));
            chk("err", 32'(U_ERR), 32'(ph == 4 && err));
            n_wr += int'(U_WREADY);
            n_rv += int'(U_RVALID);
            if (ph == 2 || ph == 3) begin
                chk("haddr", 32'(bus.HADDR), 32'(ea));
                chk("hsel", 32'(bus.HSEL), 32'(sl));
                chk("hwrite", 32'(bus.HWRITE), 32'(wr));
            end
            if (ph == 3 && wr) chk("hwdata", bus.HWDATA, wdat[b]);
            if (rst_mid && ph == 3) begin
                #2 RST = 1'b0;
                U_REQ = 1'b0;
                #1 chk_zero("rst_mid");
                return;
            end
            U_REQ = ph != 4 ? 1'($urandom) : 1'b0;
            U_ADDR = 12'($urandom); U_LEN = 4'($urandom); U_SLAVE = 2'($urandom);
            U_WRITE = 1'($urandom); U_LOCK = 1'($urandom);
            U_WDATA = ph == 2 && r == 0 ? wdat[b] : $urandom;
            bus.HGRANT = ph == 1 ? nreq >= gd : 1'($urandom);
            bus.HREADY = ph == 3 ? wc == 0 : 1'($urandom);
            bus.HRESP = ph == 3 && wc == 0 ? resp : 2'($urandom);
            bus.HRDATA = hr_idx ? 32'(b) : $urandom;
            rv_exp = 1'b0;
            case (ph)
                1: if (bus.HGRANT) ph = 2; else nreq++;
                2: begin
                    ph = 3;
                    wc = wait_q.size() > 0 ? wait_q.pop_front() : $urandom_range(0, 2);
                    resp = resp_q.size() > 0 ? resp_q.pop_front() : pick_resp();
                end
                3: if (wc > 0) wc--;
                   else if (resp == RESP_OKAY) begin
                       if (!wr) begin rv_exp = 1'b1; rd_exp = bus.HRDATA; exp_rv++; end
                       if (b == int'(len)) ph = 4;
                       else begin
                           b++; r = 0; nreq = 0;
                           gd = gdly >= 0 ? gdly : $urandom_range(0, 2);
                           ph = bus.HGRANT ? 2 : 1;
                       end
                   end else if (resp == RESP_ERROR) begin err = 1'b1; ph = 4; end
                   else begin
                       r++; nreq = 0;
                       gd = gdly >= 0 ? gdly : $urandom_range(0, 2);
                       err = r == MAX_RETRY;
                       ph = err ? 4 : 1;
                   end
                default: ph = 0;
            endcase
        end
        chk("end_state", ph, 0);
        chk("n_wready", n_wr, wr ? b + 1 : 0);
        chk("n_rvalid", n_rv, exp_rv);
        @(negedge CLK);
        chk("idle", 32'({U_BUSY, U_DONE, U_ERR, U_RVALID, bus.HREQ, bus.HLOCK}), 0);
    endtask
    initial begin
        bus.HGRANT = 1'b0; bus.HREADY = 1'b0; bus.HRESP = 2'b00; bus.HRDATA = '0;
        fill_wdat();
        #1 chk_zero("por");
        repeat (2) @(negedge CLK);
        chk_zero("reset_held");
        RST = 1'b1;
        wdat[0] = 32'hDEADBEEF;
        gdly = 2;
        run_burst(1'b1, 1'b0, 12'h010, 4'd0, 2'd1, 1'b0);
        gdly = -1;
        hr_idx = 1'b1;
        run_burst(1'b0, 1'b0, 12'h100, 4'd3, 2'd2, 1'b0);
        hr_idx = 1'b0;
        fill_wdat();
        wait_q = '{0, 5};
        run_burst(1'b1, 1'b0, 12'h200, 4'd3, 2'd3, 1'b0);
        resp_q = '{RESP_OKAY, RESP_OKAY, RESP_RETRY, RESP_OKAY, RESP_OKAY};
        run_burst(1'b1, 1'b1, 12'h300, 4'd3, 2'd1, 1'b0);
        resp_q = '{RESP_ERROR};
        run_burst(1'b1, 1'b0, 12'h040, 4'd3, 2'd0, 1'b0);
        resp_q = '{RESP_SPLIT, RESP_SPLIT, RESP_SPLIT};
        run_burst(1'b0, 1'b1, 12'h080, 4'd1, 2'd2, 1'b0);
        fill_wdat();
        run_burst(1'b1, 1'b0, 12'hFF8, 4'd3, 2'd1, 1'b0);
        run_burst(1'b1, 1'b1, 12'h500, 4'd3, 2'd1, 1'b1);
        resp_q.delete();
        wait_q.delete();
        @(negedge CLK);
        chk_zero("rst_low");
        RST = 1'b1;
        run_burst(1'b0, 1'b0, 12'h600, 4'd2, 2'd3, 1'b0);
        rnd_pct = 20;
        repeat (30) begin
            fill_wdat();
            run_burst(1'($urandom), 1'($urandom), 12'($urandom), 4'($urandom), 2'($urandom), 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_master_burst.md
BUS_MASTER_BURST -- requirements
Module: bus_master_burst

Interface
REQ-001 Parameter DATA_W, 32, width of write data and read data.
REQ-002 Parameter ADDR_W, 12, width of the byte address.
REQ-003 Parameter SLV_W, 2, width of the slave-select field.
REQ-004 Parameter LEN_W, 4, width of the burst-length field; a burst carries at most 2**LEN_W beats.
REQ-005 Parameter MAX_RETRY, 3, maximum number of RETRY/SPLIT restarts per beat before the block reports an error.
REQ-006 Ports, one per line (name, direction, width, meaning):
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- U_REQ  in  1  user start strobe; sampled in IDLE only.
- U_LOCK  in  1  hold the bus for the whole burst.
- U_WRITE  in  1  1 = write burst, 0 = read burst.
- U_ADDR  in  ADDR_W  start address.
- U_WDATA  in  DATA_W  current write beat; valid when U_WREADY is high.
- U_SLAVE  in  SLV_W  target slave.
- U_LEN  in  LEN_W  beats minus one.
- U_WREADY  out  1  write beat consumed this cycle.
- U_RDATA  out  DATA_W  captured read beat.
- U_RVALID  out  1  one-cycle pulse; U_RDATA valid.
- U_BUSY  out  1  high outside IDLE.
- U_DONE  out  1  one-cycle pulse at burst end.
- U_ERR  out  1  one-cycle pulse, together with U_DONE, on an aborted burst.
- HGRANT  in  1  arbiter grant.
- HREADY  in  1  slave data-phase complete.
- HRESP  in  2  response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- HRDATA  in  DATA_W  read data.
- HREQ  out  1  bus request.
- HLOCK  out  1  locked-transfer request.
- HSEL  out  SLV_W  slave select.
- HADDR  out  ADDR_W  transfer address.
- HWRITE  out  1  transfer direction.
- HWDATA  out  DATA_W  write data.

Function
REQ-007 State machine states: IDLE, REQ, ADDR, DATA, DONE.
REQ-008 IDLE: on U_REQ=1, latch U_LOCK, U_WRITE, U_ADDR, U_SLAVE and U_LEN; clear the beat and retry counters; go to REQ.
REQ-009 REQ: assert HREQ (and HLOCK if the locked bit is set); go to ADDR on the first cycle with HGRANT=1.
REQ-010 ADDR (exactly one cycle): drive HADDR, HSEL and HWRITE; for a write, register U_WDATA into HWDATA and pulse U_WREADY; go to DATA.
REQ-011 DATA: hold HADDR, HSEL, HWRITE and HWDATA stable until HREADY=1, then evaluate HRESP.
REQ-012 DATA with HREADY=1 and HRESP=OKAY:
- read: U_RDATA<=HRDATA, pulse U_RVALID next cycle.
- last beat: go to DONE.
- otherwise: beat+1, address+(DATA_W/8), clear the retry counter, go to ADDR if HGRANT=1, else go to REQ.
REQ-013 HRESP=ERROR: abort the burst; go to DONE with the error flag set.
REQ-014 HRESP=RETRY or SPLIT: retry counter+1 and return to REQ to replay the same beat.
- The replayed write beat reuses the held HWDATA; U_WREADY does not pulse again.
- If the retry counter reaches MAX_RETRY, abort as for ERROR.
REQ-015 DONE (one cycle): pulse U_DONE, and U_ERR if the error flag is set; deassert HREQ and HLOCK; go to IDLE.
REQ-016 HLOCK stays high from REQ through the last DATA cycle of a locked burst, including across retries.
REQ-017 HREQ is high in REQ, ADDR and DATA, and low in IDLE and DONE.
REQ-018 The address wraps modulo 2**ADDR_W; there is no 1 KB boundary check.
REQ-019 U_REQ outside IDLE is ignored; the latched request fields are immutable until DONE.
REQ-020 HGRANT lost during DATA does not abort the current beat; it is sampled only at REQ and at the beat boundary.

Reset
REQ-021 RST=0 asynchronously forces IDLE and clears all counters and flags.
REQ-022 RST=0 drives every output to 0: HREQ, HLOCK, HSEL, HADDR, HWRITE, HWDATA, U_WREADY, U_RDATA, U_RVALID, U_BUSY, U_DONE, U_ERR.
REQ-023 Reset mid-burst discards the burst with no U_DONE pulse; the first U_REQ is accepted on the first CLK edge after RST returns to 1.

Structure
REQ-024 A shared package bus_pkg holds:
- HRESP encodings (RESP_OKAY, RESP_ERROR, RESP_RETRY, RESP_SPLIT).
- the master state enum.
- the DATA_W, ADDR_W and SLV_W defaults.
REQ-025 One sub-module, bus_beat_ctr, holds the beat/address counter: load start address and length, increment by DATA_W/8, assert last.

Verification
REQ-026 Single write: U_ADDR=0x010, U_LEN=0, U_WDATA=0xDEADBEEF, HGRANT after 2 cycles, HREADY=1 -> HADDR=0x010, HWDATA=0xDEADBEEF, one U_WREADY, U_DONE=1, U_ERR=0.
REQ-027 Read burst: U_LEN=3, U_ADDR=0x100, HRDATA=beat index -> HADDR 0x100, 0x104, 0x108, 0x10C; four U_RVALID pulses with U_RDATA 0..3; then U_DONE.
REQ-028 Wait states: HREADY low for 5 cycles on beat 1 -> HADDR and HWDATA stable throughout; total beats unchanged.
REQ-029 RETRY: beat 2 of 4 answers RETRY once -> HREQ reasserted, beat 2 replayed at the same address and data, U_WREADY pulses exactly 4 times, U_ERR=0.
REQ-030 Abort cases:
- ERROR on beat 0 -> U_DONE and U_ERR in the same cycle, no further HADDR.
- MAX_RETRY=3 consecutive SPLITs -> the same abort.
REQ-031 Async reset: RST=0 mid-DATA -> all outputs 0 immediately; after release, a new U_REQ completes normally.
